// File: rtl/uart_reg_bridge.sv
// UART FIFO to register-bus bridge: parses 'W' addr data / 'R' addr commands and replies with one byte.
// Optional trailing XOR checksum byte when UART_REG_BRIDGE_CHKSUM_EN is defined.
module uart_reg_bridge #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] R_data,
  input  logic                  rx_empty,
  output logic                  rd_uart,
  output logic [DATA_WIDTH-1:0] W_data,
  output logic                  wr_uart,
  input  logic                  tx_full,
  output logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_req,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = 8'h57;
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = 8'h52;
  localparam logic [DATA_WIDTH-1:0] RSP_OK    = 8'h4B;
  localparam logic [DATA_WIDTH-1:0] RSP_ERR   = 8'h45;
  localparam logic [DATA_WIDTH-1:0] RSP_TMO   = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_CHK,
    S_BUS,
    S_SEND
  } state_t;

`ifdef UART_REG_BRIDGE_CHKSUM_EN
  localparam state_t S_CMD_DONE = S_GET_CHK;
  logic [DATA_WIDTH-1:0] chk;
`else
  localparam state_t S_CMD_DONE = S_BUS;
`endif

  state_t           state;
  logic             cmd_wr;    // latched command is a write
  logic             resp_err;  // pending reply came from an E or T path
  logic [CNT_W-1:0] tmo_cnt;
  logic             fetch;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fetch = 1'b0;
    case (state)
      S_IDLE, S_GET_ADDR, S_GET_DATA: fetch = 1'b1;
`ifdef UART_REG_BRIDGE_CHKSUM_EN
      S_GET_CHK:                      fetch = 1'b1;
`endif
      default:                        fetch = 1'b0;
    endcase
  end

  // FIFO handshakes are combinational so a waiting byte is consumed on the very next edge.
  assign rd_uart = fetch && !rx_empty;
  assign wr_uart = (state == S_SEND) && !tx_full;
  assign busy    = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_wr    <= 1'b0;
      resp_err  <= 1'b0;
      tmo_cnt   <= '0;
      W_data    <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_req   <= 1'b0;
      err_count <= 8'h00;
`ifdef UART_REG_BRIDGE_CHKSUM_EN
      chk       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_uart) begin
`ifdef UART_REG_BRIDGE_CHKSUM_EN
            chk <= R_data;
`endif
            if (R_data == CMD_WRITE || R_data == CMD_READ) begin
              cmd_wr <= (R_data == CMD_WRITE);
              state  <= S_GET_ADDR;
            end else begin
              W_data   <= RSP_ERR;
              resp_err <= 1'b1;
              state    <= S_SEND;
            end
          end
        end

        S_GET_ADDR: begin
          if (rd_uart) begin
`ifdef UART_REG_BRIDGE_CHKSUM_EN
            chk <= chk ^ R_data;
`endif
            reg_addr <= R_data;
            state    <= cmd_wr ? S_GET_DATA : S_CMD_DONE;
          end
        end

        S_GET_DATA: begin
          if (rd_uart) begin
`ifdef UART_REG_BRIDGE_CHKSUM_EN
            chk <= chk ^ R_data;
`endif
            reg_wdata <= R_data;
            state     <= S_CMD_DONE;
          end
        end

`ifdef UART_REG_BRIDGE_CHKSUM_EN
        S_GET_CHK: begin
          if (rd_uart) begin
            if (R_data == chk) begin
              state <= S_BUS;
            end else begin
              W_data   <= RSP_ERR;
              resp_err <= 1'b1;
              state    <= S_SEND;
            end
          end
        end
`endif

        S_BUS: begin
          // First BUS cycle raises the request; ack is only honoured once reg_req is visible.
          if (!reg_req) begin
            reg_req <= 1'b1;
            reg_we  <= cmd_wr;
          end else if (reg_ack) begin
            reg_req  <= 1'b0;
            tmo_cnt  <= '0;
            W_data   <= cmd_wr ? RSP_OK : reg_rdata;
            resp_err <= 1'b0;
            state    <= S_SEND;
          end else if (tmo_cnt == CNT_LAST) begin
            reg_req  <= 1'b0;
            tmo_cnt  <= '0;
            W_data   <= RSP_TMO;
            resp_err <= 1'b1;
            state    <= S_SEND;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_ONE;
          end
        end

        S_SEND: begin
          if (!tx_full) begin
            state <= S_IDLE;
            if (resp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: RX FIFO and register-bus models with reply/bus scoreboards.
module tb_uart_reg_bridge;

  logic       UCLK = 1'b0;
  logic       reset;
  logic [7:0] R_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] W_data;
  logic       wr_uart;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_req;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_count;

  uart_reg_bridge #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .UCLK(UCLK), .reset(reset), .R_data(R_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .W_data(W_data), .wr_uart(wr_uart), .tx_full(tx_full), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_req(reg_req), .reg_ack(reg_ack),
    .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
  );

  always #5 UCLK = ~UCLK;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         len;
  } bus_exp_t;

  typedef enum int {ACK_TIED, ACK_DELAY, ACK_NEVER} ack_mode_t;

  bus_exp_t   exp_bus[$];
  bus_exp_t   cur_bus;
  logic [7:0] exp_reply[$];
  logic [7:0] rx_q[$];
  ack_mode_t  ack_mode = ACK_TIED;
  int         ack_delay = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_err = 0;
  int         cyc = 0;
  int         n_pop = 0;
  int         n_push = 0;
  int         first_pop_cyc = -1;
  int         push_cyc = -1;
  int         req_len = 0;
  logic       in_req = 1'b0;
  logic       rd_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic void refresh_rx();
    R_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    rx_empty = (rx_q.size() == 0);
  endfunction

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  task automatic expect_reply(input logic [7:0] b, input bit is_err);
    exp_reply.push_back(b);
    if (is_err && exp_err < 255) exp_err++;
  endtask

  task automatic expect_bus(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input int len);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.len = len;
    exp_bus.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge UCLK);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      done = (exp_reply.size() == 0) && (exp_bus.size() == 0) && (rx_q.size() == 0) && !busy;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rd_uart"},   32'(rd_uart),   32'd0);
    check({pfx, "_wr_uart"},   32'(wr_uart),   32'd0);
    check({pfx, "_W_data"},    32'(W_data),    32'h00);
    check({pfx, "_reg_addr"},  32'(reg_addr),  32'h00);
    check({pfx, "_reg_wdata"}, 32'(reg_wdata), 32'h00);
    check({pfx, "_reg_we"},    32'(reg_we),    32'd0);
    check({pfx, "_reg_req"},   32'(reg_req),   32'd0);
    check({pfx, "_busy"},      32'(busy),      32'd0);
    check({pfx, "_err_count"}, 32'(err_count), 32'h00);
  endtask

  // RX FIFO model: a pop seen at the negedge takes effect at the following posedge.
  always @(posedge UCLK) begin
    cyc++;
    #1;
    if (rd_pend && !reset && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      n_pop++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    refresh_rx();
  end

  // Monitors sample mid-cycle; the bus responder drives reg_ack for the coming edge.
  always @(negedge UCLK) begin
    rd_pend = rd_uart;
    if (rx_empty) check("rd_while_empty", 32'(rd_uart), 32'd0);
    if (tx_full)  check("wr_while_full", 32'(wr_uart), 32'd0);

    if (reset) begin
      in_req = 1'b0;
    end else if (reg_req) begin
      if (!in_req) begin
        in_req  = 1'b1;
        req_len = 0;
        if (exp_bus.size() == 0) begin
          check("req_unexpected", 32'(exp_bus.size()), 32'd1);
          cur_bus.len = 0;
        end else begin
          cur_bus = exp_bus.pop_front();
          check("req_we",   32'(reg_we),   32'(cur_bus.we));
          check("req_addr", 32'(reg_addr), 32'(cur_bus.addr));
          if (cur_bus.we) check("req_wdata", 32'(reg_wdata), 32'(cur_bus.wdata));
        end
      end
      req_len++;
    end else if (in_req) begin
      in_req = 1'b0;
      if (cur_bus.len > 0) check("req_len", 32'(req_len), 32'(cur_bus.len));
    end

    case (ack_mode)
      ACK_TIED:  reg_ack = 1'b1;
      ACK_DELAY: reg_ack = reg_req && !reset && (req_len > ack_delay);
      default:   reg_ack = 1'b0;
    endcase

    if (!reset && wr_uart) begin
      n_push++;
      if (push_cyc < 0) push_cyc = cyc + 1;
      if (exp_reply.size() == 0) check("reply_unexpected", 32'(exp_reply.size()), 32'd1);
      else                       check("reply", 32'(W_data), 32'(exp_reply.pop_front()));
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_pop;
    int base_push;
    bit seen;
    logic [7:0] sv_bytes [3];

    reset = 1'b1; tx_full = 1'b0; reg_ack = 1'b0; reg_rdata = 8'h00;
    refresh_rx();
    tick(3);
    check_reset_values("rst0");
    reset = 1'b0;
    tick(2);

    // Write with ack tied high: ack outside reg_req must be ignored.
    ack_mode = ACK_TIED;
    first_pop_cyc = -1; push_cyc = -1; base_pop = n_pop;
    expect_bus(1'b1, 8'h10, 8'hA5, 1);
    expect_reply(8'h4B, 0);
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hA5);
    wait_idle("wr_done", 100);
    check("wr_pops", 32'(n_pop - base_pop), 32'd3);
    check("wr_latency", 32'(push_cyc - first_pop_cyc), 32'd5);
    check("wr_addr_hold", 32'(reg_addr), 32'h10);
    check("wr_wdata_hold", 32'(reg_wdata), 32'hA5);
    check("wr_err", 32'(err_count), 32'(exp_err));

    // Read with ack on the fourth request cycle.
    ack_mode = ACK_DELAY; ack_delay = 3; reg_rdata = 8'h3C;
    expect_bus(1'b0, 8'h22, 8'h00, 4);
    expect_reply(8'h3C, 0);
    push_rx(8'h52); push_rx(8'h22);
    wait_idle("rd_done", 100);
    check("rd_err", 32'(err_count), 32'(exp_err));

    // Unknown command, then a normal read.
    ack_delay = 0;
    expect_reply(8'h45, 1);
    push_rx(8'h99);
    wait_idle("bad_done", 100);
    check("bad_err", 32'(err_count), 32'(exp_err));
    reg_rdata = 8'h5A;
    expect_bus(1'b0, 8'h01, 8'h00, 1);
    expect_reply(8'h5A, 0);
    push_rx(8'h52); push_rx(8'h01);
    wait_idle("after_bad_done", 100);
    check("after_bad_err", 32'(err_count), 32'(exp_err));

    // Bus timeout after TIMEOUT_CYCLES request cycles.
    ack_mode = ACK_NEVER;
    expect_bus(1'b0, 8'h05, 8'h00, 8);
    expect_reply(8'h54, 1);
    push_rx(8'h52); push_rx(8'h05);
    wait_idle("tmo_done", 100);
    check("tmo_err", 32'(err_count), 32'(exp_err));

    // RX starvation: one byte every 20 cycles.
    ack_mode = ACK_DELAY; ack_delay = 1;
    sv_bytes[0] = 8'h57; sv_bytes[1] = 8'h33; sv_bytes[2] = 8'hC3;
    base_pop = n_pop;
    expect_bus(1'b1, 8'h33, 8'hC3, 2);
    expect_reply(8'h4B, 0);
    for (int i = 0; i < 3; i++) begin
      push_rx(sv_bytes[i]);
      for (int j = 0; j < 20; j++) begin
        tick(1);
        if (i < 2) check("starve_busy", 32'(busy), 32'd1);
      end
      check("starve_pops", 32'(n_pop - base_pop), 32'(i + 1));
    end
    wait_idle("starve_done", 100);

    // TX back-pressure held for 10 cycles in SEND.
    ack_delay = 0; reg_rdata = 8'h77; tx_full = 1'b1;
    expect_bus(1'b0, 8'h44, 8'h00, 1);
    expect_reply(8'h77, 0);
    push_rx(8'h52); push_rx(8'h44);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick(1);
      seen = (exp_bus.size() == 0) && !reg_req && (rx_q.size() == 0);
    end
    check("bp_bus_done", 32'(seen), 32'd1);
    base_push = n_push;
    tick(10);
    check("bp_no_push", 32'(n_push - base_push), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    tx_full = 1'b0;
    wait_idle("bp_done", 100);
    check("bp_one_push", 32'(n_push - base_push), 32'd1);
    check("pre_rst_err", 32'(err_count), 32'(exp_err));

    // Reset while the bus request is outstanding.
    ack_mode = ACK_NEVER;
    expect_bus(1'b0, 8'h66, 8'h00, 0);
    expect_reply(8'h00, 0);
    push_rx(8'h52); push_rx(8'h66);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick(1);
      seen = reg_req;
    end
    check("rst_req_seen", 32'(seen), 32'd1);
    tick(2);
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid");
    exp_reply.delete();
    exp_bus.delete();
    exp_err = 0;
    tick(2);
    reset = 1'b0;
    tick(1);

    ack_mode = ACK_TIED;
    expect_bus(1'b1, 8'h01, 8'h02, 1);
    expect_reply(8'h4B, 0);
    push_rx(8'h57); push_rx(8'h01); push_rx(8'h02);
    wait_idle("post_rst_done", 100);
    check("post_rst_err", 32'(err_count), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
